// File: rtl/uart8_cpu_oci_dct_packer.sv
// Trace symbol packer: collects 2-bit trace symbols into a 30-bit word.
// A word is offered downstream when it reaches MAX_COUNT symbols, on flush,
// or while draining for end-of-test. The end-of-test sequence reports a
// one-cycle test_ending pulse followed by a sticky test_has_ended flag.
module uart8_cpu_oci_dct_packer #(
    parameter int MAX_COUNT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sym_valid,
    input  logic [1:0]  sym_data,
    output logic        sym_ready,
    input  logic        flush,
    input  logic        end_req,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        test_ending,
    output logic        test_has_ended
);

    localparam logic [3:0] MAX_C = 4'(MAX_COUNT);

    typedef enum logic [1:0] {FILL, HOLD, ENDING, ENDED} state_t;

    state_t     state, state_nxt;
    logic       end_pending, end_pending_nxt;
    logic       accept;
    logic       xfer;
    logic       end_eff;
    logic [3:0] cnt_acc;

    // Symbols only enter while filling; reset blocks acceptance immediately.
    assign sym_ready      = (state == FILL) && reset_n;
    assign accept         = sym_valid && sym_ready;
    assign xfer           = (state == HOLD) && out_ready;
    // Count as it will be after this cycle's accept, used for flush/end decisions.
    assign cnt_acc        = dct_count + {3'b000, accept};

    // Status outputs are decoded straight from the state register.
    assign out_valid      = (state == HOLD);
    assign test_ending    = (state == ENDING);
    assign test_has_ended = (state == ENDED);

    // State and end-pending registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FILL;
            end_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            end_pending <= end_pending_nxt;
        end
    end

    // Next-state logic. An end request dominates flush; a word that fills
    // on the same cycle as a flush still produces only that one word.
    always_comb begin
        state_nxt       = state;
        end_pending_nxt = end_pending;
        end_eff         = 1'b0;
        case (state)
            FILL: begin
                end_eff = end_pending || end_req;
                if (end_req) end_pending_nxt = 1'b1;
                if (accept && (cnt_acc == MAX_C))
                    state_nxt = HOLD;
                else if (end_eff)
                    state_nxt = (cnt_acc != 4'd0) ? HOLD : ENDING;
                else if (flush && (cnt_acc != 4'd0))
                    state_nxt = HOLD;
            end
            HOLD: begin
                end_eff = end_pending || end_req;
                if (end_req) end_pending_nxt = 1'b1;
                if (xfer) state_nxt = end_eff ? ENDING : FILL;
            end
            ENDING:  state_nxt = ENDED;
            default: state_nxt = ENDED;
        endcase
    end

    // Word datapath: shift in on accept, clear once the consumer takes the word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end else if (accept) begin
            dct_buffer <= {dct_buffer[27:0], sym_data};
            dct_count  <= cnt_acc;
        end else if (xfer) begin
            dct_buffer <= '0;
            dct_count  <= '0;
        end
    end

endmodule

// File: tb/tb_uart8_cpu_oci_dct_packer.sv
// Directed bench for the trace symbol packer (MAX_COUNT = 15).
module tb_uart8_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sym_valid;
    logic [1:0]  sym_data;
    logic        sym_ready;
    logic        flush;
    logic        end_req;
    logic        out_ready;
    logic        out_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;

    int errors = 0;
    int checks = 0;

    uart8_cpu_oci_dct_packer #(.MAX_COUNT(15)) dut (
        .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_ready(sym_ready), .flush(flush), .end_req(end_req), .out_ready(out_ready),
        .out_valid(out_valid), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sym_valid = 1'b0; sym_data = 2'b00; flush = 1'b0; end_req = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b0;
        reset_n = 1'b0;
        cyc(); cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (dct_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", dct_count); end
        checks++; if (dct_buffer !== 30'h0) begin errors++; $display("FAIL reset_buffer got=%h exp=0", dct_buffer); end
        checks++; if (test_ending !== 1'b0 || test_has_ended !== 1'b0) begin errors++; $display("FAIL reset_end_flags got=%b%b exp=00", test_ending, test_has_ended); end
        checks++; if (sym_ready !== 1'b0) begin errors++; $display("FAIL reset_sym_ready_low got=%b exp=0", sym_ready); end
        reset_n = 1'b1;
        cyc();
        checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL reset_sym_ready_high got=%b exp=1", sym_ready); end
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        sym_valid = 1'b1; sym_data = 2'b11;
        for (int i = 0; i < 14; i++) cyc();
        checks++; if (out_valid !== 1'b0 || dct_count !== 4'd14) begin errors++; $display("FAIL full_14 got ov=%b cnt=%0d exp ov=0 cnt=14", out_valid, dct_count); end
        cyc();
        sym_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || dct_buffer !== 30'h3FFFFFFF || dct_count !== 4'd15)
            begin errors++; $display("FAIL full_word got ov=%b buf=%h cnt=%0d exp ov=1 buf=3fffffff cnt=15", out_valid, dct_buffer, dct_count); end
        cyc();
        checks++; if (out_valid !== 1'b0 || dct_buffer !== 30'h0 || dct_count !== 4'd0 || sym_ready !== 1'b1)
            begin errors++; $display("FAIL full_cleared got ov=%b buf=%h cnt=%0d rdy=%b exp 0/0/0/1", out_valid, dct_buffer, dct_count, sym_ready); end
    endtask

    task automatic test_flush();
        logic [1:0] syms [3] = '{2'b01, 2'b10, 2'b11};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sym_valid = 1'b1; sym_data = syms[i];
            cyc();
        end
        sym_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1 || dct_buffer !== 30'h1B || dct_count !== 4'd3)
            begin errors++; $display("FAIL flush_word got ov=%b buf=%h cnt=%0d exp ov=1 buf=1b cnt=3", out_valid, dct_buffer, dct_count); end
        out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0 || dct_count !== 4'd0) begin errors++; $display("FAIL flush_xfer got ov=%b cnt=%0d exp ov=0 cnt=0", out_valid, dct_count); end
    endtask

    task automatic test_flush_empty();
        out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || sym_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, sym_ready); end
    endtask

    task automatic test_flush_with_accept();
        out_ready = 1'b0;
        sym_valid = 1'b1; sym_data = 2'b10; flush = 1'b1;
        cyc();
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || dct_buffer !== 30'h2 || dct_count !== 4'd1)
            begin errors++; $display("FAIL flush_same_cycle got ov=%b buf=%h cnt=%0d exp ov=1 buf=2 cnt=1", out_valid, dct_buffer, dct_count); end
        out_ready = 1'b1;
        cyc();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        sym_valid = 1'b1; sym_data = 2'b10;
        for (int i = 0; i < 15; i++) cyc();
        sym_data = 2'b01;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            checks++; if (out_valid !== 1'b1 || dct_buffer !== 30'h2AAAAAAA || dct_count !== 4'd15 || sym_ready !== 1'b0)
                begin errors++; $display("FAIL backpressure_hold%0d got ov=%b buf=%h cnt=%0d rdy=%b exp ov=1 buf=2aaaaaaa cnt=15 rdy=0", i, out_valid, dct_buffer, dct_count, sym_ready); end
            cyc();
        end
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || dct_count !== 4'd15) begin errors++; $display("FAIL backpressure_still got ov=%b cnt=%0d exp ov=1 cnt=15", out_valid, dct_count); end
        out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0 || dct_count !== 4'd0) begin errors++; $display("FAIL backpressure_xfer got ov=%b cnt=%0d exp ov=0 cnt=0", out_valid, dct_count); end
    endtask

    task automatic test_max_with_flush();
        out_ready = 1'b0;
        sym_valid = 1'b1; sym_data = 2'b01;
        for (int i = 0; i < 14; i++) cyc();
        flush = 1'b1;
        cyc();
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || dct_buffer !== 30'h15555555 || dct_count !== 4'd15)
            begin errors++; $display("FAIL max_flush_word got ov=%b buf=%h cnt=%0d exp ov=1 buf=15555555 cnt=15", out_valid, dct_buffer, dct_count); end
        out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_flush_xfer got ov=%b exp 0", out_valid); end
        cyc();
        checks++; if (out_valid !== 1'b0 || dct_count !== 4'd0) begin errors++; $display("FAIL max_flush_single got ov=%b cnt=%0d exp ov=0 cnt=0", out_valid, dct_count); end
    endtask

    task automatic test_end_partial();
        out_ready = 1'b0;
        sym_valid = 1'b1; sym_data = 2'b01; cyc();
        sym_data = 2'b10; cyc();
        sym_valid = 1'b0; end_req = 1'b1;
        cyc();
        end_req = 1'b0;
        checks++; if (out_valid !== 1'b1 || dct_count !== 4'd2 || dct_buffer !== 30'h6 || test_ending !== 1'b0)
            begin errors++; $display("FAIL end_partial_hold got ov=%b cnt=%0d buf=%h te=%b exp ov=1 cnt=2 buf=6 te=0", out_valid, dct_count, dct_buffer, test_ending); end
        out_ready = 1'b1;
        cyc();
        checks++; if (out_valid !== 1'b0 || test_ending !== 1'b1 || sym_ready !== 1'b0)
            begin errors++; $display("FAIL end_partial_ending got ov=%b te=%b rdy=%b exp ov=0 te=1 rdy=0", out_valid, test_ending, sym_ready); end
        cyc();
        checks++; if (test_ending !== 1'b0 || test_has_ended !== 1'b1 || sym_ready !== 1'b0)
            begin errors++; $display("FAIL end_partial_ended got te=%b the=%b rdy=%b exp te=0 the=1 rdy=0", test_ending, test_has_ended, sym_ready); end
        sym_valid = 1'b1; flush = 1'b1; end_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (test_has_ended !== 1'b1 || test_ending !== 1'b0 || out_valid !== 1'b0 || sym_ready !== 1'b0 || dct_count !== 4'd0)
                begin errors++; $display("FAIL ended_sticky%0d got the=%b te=%b ov=%b rdy=%b cnt=%0d exp 1/0/0/0/0", i, test_has_ended, test_ending, out_valid, sym_ready, dct_count); end
        end
        idle_inputs();
    endtask

    task automatic test_end_empty();
        do_reset();
        flush = 1'b1; end_req = 1'b1;
        cyc();
        idle_inputs();
        checks++; if (test_ending !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL end_empty_ending got te=%b ov=%b exp te=1 ov=0", test_ending, out_valid); end
        cyc();
        checks++; if (test_ending !== 1'b0 || test_has_ended !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL end_empty_ended got te=%b the=%b ov=%b exp te=0 the=1 ov=0", test_ending, test_has_ended, out_valid); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        out_ready = 1'b0;
        sym_valid = 1'b1; sym_data = 2'b11;
        for (int i = 0; i < 3; i++) cyc();
        sym_valid = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b1 || dct_count !== 4'd3) begin errors++; $display("FAIL rst_hold_pre got ov=%b cnt=%0d exp ov=1 cnt=3", out_valid, dct_count); end
        reset_n = 1'b0;
        cyc();
        checks++; if (out_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'h0 || sym_ready !== 1'b0 || test_ending !== 1'b0 || test_has_ended !== 1'b0)
            begin errors++; $display("FAIL rst_hold_clear got ov=%b cnt=%0d buf=%h rdy=%b te=%b the=%b exp all 0", out_valid, dct_count, dct_buffer, sym_ready, test_ending, test_has_ended); end
        reset_n = 1'b1;
        #1;
        checks++; if (sym_ready !== 1'b1) begin errors++; $display("FAIL rst_hold_ready got=%b exp=1", sym_ready); end
        cyc();
        checks++; if (out_valid !== 1'b0 || sym_ready !== 1'b1) begin errors++; $display("FAIL rst_hold_fill got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, sym_ready); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_flush_empty();
        test_flush_with_accept();
        test_backpressure();
        test_max_with_flush();
        test_end_partial();
        test_end_empty();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart8_cpu_oci_dct_packer.md
UART8_CPU_OCI_DCT_PACKER -- requirements
Module: uart8_cpu_oci_dct_packer

Interface
REQ-001 Parameter MAX_COUNT, default 15, symbols per packed word; legal range 1..15.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 sym_valid  in  1  trace symbol offered.
REQ-005 sym_data  in  2  trace symbol code.
REQ-006 sym_ready  out  1  packer accepts symbol this cycle.
REQ-007 flush  in  1  single-cycle request to emit partial word.
REQ-008 end_req  in  1  single-cycle request to drain and end the test.
REQ-009 out_ready  in  1  consumer accepts packed word.
REQ-010 out_valid  out  1  dct_buffer/dct_count hold a complete word.
REQ-011 dct_buffer  out  30  packed symbols; newest in bits [1:0].
REQ-012 dct_count  out  4  number of valid symbols in dct_buffer.
REQ-013 test_ending  out  1  one-cycle pulse: drain finished.
REQ-014 test_has_ended  out  1  sticky end flag.

Function
REQ-015 States: FILL, HOLD, ENDING, ENDED; the FSM SHALL be in FILL after reset.
REQ-016 sym_ready SHALL be 1 only in FILL and only while reset_n is high.
REQ-017 An accept (sym_valid && sym_ready) SHALL update dct_buffer <= {dct_buffer[27:0], sym_data} and dct_count <= dct_count+1 on the same edge.
REQ-018 dct_buffer and dct_count SHALL be registered outputs, visible at all times; out_valid qualifies them.
REQ-019 FILL->HOLD when an accept makes dct_count reach MAX_COUNT; out_valid SHALL be 1 on the next cycle.
REQ-020 FILL->HOLD on flush when dct_count>0 after any same-cycle accept; a same-cycle symbol SHALL be included in the word.
REQ-021 flush with dct_count==0 and no accept SHALL be ignored.
REQ-022 In HOLD, out_valid=1, dct_buffer and dct_count SHALL stay stable and flush SHALL be ignored until out_valid && out_ready.
REQ-023 On transfer in HOLD, dct_buffer<=0, dct_count<=0, out_valid<=0; next state FILL, or ENDING if an end is pending.
REQ-024 end_req SHALL set an internal end_pending flag; end_req in ENDING or ENDED SHALL be ignored.
REQ-025 In FILL with end_pending: if dct_count>0 after any same-cycle accept, go to HOLD; else go to ENDING.
REQ-026 ENDING SHALL last exactly one cycle with test_ending=1, then go to ENDED.
REQ-027 In ENDED, test_has_ended=1 and sym_ready=0 until reset; flush and end_req SHALL have no effect.
REQ-028 Simultaneous flush and end_req SHALL behave as end_req alone.
REQ-029 A MAX_COUNT-reaching accept together with flush SHALL produce one word, not two.
REQ-030 The maximum word rate SHALL be one per MAX_COUNT+1 cycles; symbol-to-out_valid latency SHALL be 1 cycle.

Reset
REQ-031 With reset_n low at an edge: state FILL, dct_buffer=0, dct_count=0, out_valid=0, test_ending=0, test_has_ended=0, end_pending=0.
REQ-032 Reset SHALL take priority over every other input, including mid-HOLD and in ENDED; the partial word is discarded.

Verification
REQ-033 15 accepts of 2'b11, out_ready=1 (MAX_COUNT=15) -> out_valid=1 next cycle, dct_buffer=30'h3FFFFFFF, dct_count=15; cleared one cycle later.
REQ-034 Accept 01, 10, 11, then flush -> dct_buffer=30'h1B, dct_count=3, out_valid=1.
REQ-035 Full word with out_ready=0 for 5 cycles -> out_valid, dct_buffer and dct_count stable, sym_ready=0; transfer on cycle 6.
REQ-036 Accept 2 symbols, then end_req -> HOLD with dct_count=2; after transfer, one-cycle test_ending, then test_has_ended=1 and sym_ready=0 permanently.
REQ-037 end_req with dct_count=0 -> test_ending on the next cycle with no out_valid.
REQ-038 reset_n low for 1 cycle during HOLD -> all outputs 0, then sym_ready=1 once reset_n is high.
